// File: rtl/dcache_controller_if.sv
// CPU-side (p1_) and memory-side (mem_) signal bundle for the L1 data cache.
// The cache binds to the slave modport; the CPU/memory side binds to master.
interface dcache_controller_if;
   logic         p1_MemRead_i;
   logic         p1_MemWrite_i;
   logic [31:0]  p1_addr_i;
   logic [31:0]  p1_data_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport master (
      output p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
      input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Hits are zero-latency;
// misses stall the pipeline while an optional writeback and a line refill run.
module dcache_controller #(
   parameter int unsigned LINES     = 32,
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned TAG_BITS  = 22
) (
   input logic                clk_i,
   input logic                rst_i,
   dcache_controller_if.slave bus
);
   localparam int unsigned IDX_BITS  = $clog2(LINES);
   localparam int unsigned WORDS     = LINE_BITS / 32;
   localparam int unsigned WORD_BITS = $clog2(WORDS);
   localparam int unsigned OFF_BITS  = $clog2(LINE_BITS / 8);

   typedef enum logic [2:0] {
      StIdle,
      StMiss,
      StWriteback,
      StRefill,
      StRefillDone
   } state_e;

   state_e                r_state;
   state_e                w_state_next;

   logic [LINES-1:0]      r_valid;
   logic [LINES-1:0]      r_dirty;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [LINE_BITS-1:0]  r_data [LINES];

   logic                  r_mem_enable;
   logic                  r_mem_write;
   logic [31:0]           r_mem_addr;
   logic [LINE_BITS-1:0]  r_mem_data;
   logic                  w_mem_enable_next;
   logic                  w_mem_write_next;
   logic [31:0]           w_mem_addr_next;
   logic [LINE_BITS-1:0]  w_mem_data_next;

   logic [TAG_BITS-1:0]   w_tag;
   logic [IDX_BITS-1:0]   w_index;
   logic [WORD_BITS-1:0]  w_word;
   logic [7:0]            w_word_base;
   logic [LINE_BITS-1:0]  w_line;
   logic                  w_req;
   logic                  w_hit;
   logic                  w_read_hit;
   logic                  w_write_hit;
   logic                  w_refill;
   logic                  w_unused;

   assign w_tag       = bus.p1_addr_i[31 -: TAG_BITS];
   assign w_index     = bus.p1_addr_i[OFF_BITS +: IDX_BITS];
   assign w_word      = bus.p1_addr_i[2 +: WORD_BITS];
   assign w_word_base = {w_word, 5'b0};
   assign w_unused    = &{1'b0, bus.p1_addr_i[1:0]};

   assign w_line      = r_data[w_index];
   assign w_req       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   // A simultaneous read and write is a store, so it returns no load data.
   assign w_read_hit  = bus.p1_MemRead_i && !bus.p1_MemWrite_i && w_hit;
   assign w_write_hit = (r_state == StIdle) && bus.p1_MemWrite_i && w_hit;

   assign bus.p1_data_o    = w_read_hit ? w_line[w_word_base +: 32] : 32'h0;
   assign bus.p1_stall_o   = (r_state != StIdle) || (w_req && !w_hit);
   assign bus.mem_enable_o = r_mem_enable;
   assign bus.mem_write_o  = r_mem_write;
   assign bus.mem_addr_o   = r_mem_addr;
   assign bus.mem_data_o   = r_mem_data;

   // Memory outputs are registered, so they are computed here from the next state.
   always_comb begin
      w_state_next      = r_state;
      w_mem_enable_next = r_mem_enable;
      w_mem_write_next  = r_mem_write;
      w_mem_addr_next   = r_mem_addr;
      w_mem_data_next   = r_mem_data;
      w_refill          = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_req && !w_hit) begin
               w_state_next = StMiss;
            end
         end
         StMiss: begin
            w_mem_enable_next = 1'b1;
            if (r_valid[w_index] && r_dirty[w_index]) begin
               w_state_next     = StWriteback;
               w_mem_write_next = 1'b1;
               w_mem_addr_next  = {r_tag[w_index], w_index, {OFF_BITS{1'b0}}};
               w_mem_data_next  = r_data[w_index];
            end else begin
               w_state_next     = StRefill;
               w_mem_write_next = 1'b0;
               w_mem_addr_next  = {w_tag, w_index, {OFF_BITS{1'b0}}};
            end
         end
         StWriteback: begin
            if (bus.mem_ack_i) begin
               w_state_next     = StRefill;
               w_mem_write_next = 1'b0;
               w_mem_addr_next  = {w_tag, w_index, {OFF_BITS{1'b0}}};
            end
         end
         StRefill: begin
            if (bus.mem_ack_i) begin
               w_state_next      = StRefillDone;
               w_mem_enable_next = 1'b0;
               w_refill          = 1'b1;
            end
         end
         StRefillDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next      = StIdle;
            w_mem_enable_next = 1'b0;
            w_mem_write_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= StIdle;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_mem_enable <= w_mem_enable_next;
         r_mem_write  <= w_mem_write_next;
         r_mem_addr   <= w_mem_addr_next;
         r_mem_data   <= w_mem_data_next;
         if (w_refill) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
         end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
         end
      end
   end

   // Tag and data arrays need no reset; validity alone qualifies them.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (w_refill) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= bus.mem_data_i;
         end else if (w_write_hit) begin
            r_data[w_index][w_word_base +: 32] <= bus.p1_data_i;
         end
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a fixed-latency line memory.
module tb_dcache_controller;
   localparam int MEM_LAT = 9;

   logic clk;
   logic rst;
   dcache_controller_if bus ();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [255:0] mem_lines [128];
   bit           mem_auto;
   int           lat_cnt;
   int           n_checks;
   int           n_pass;

   int           wb_seen;
   logic [31:0]  wb_addr;
   logic [255:0] wb_data;
   int           rf_seen;
   logic [31:0]  rf_addr;
   int           rf_write_bad;

   // Ack arrives MEM_LAT cycles after the request first becomes visible.
   initial begin
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      lat_cnt        = 0;
      forever begin
         @(negedge clk);
         if (mem_auto) begin
            bus.mem_ack_i = 1'b0;
            if (bus.mem_enable_o && !rst) begin
               lat_cnt++;
               if (lat_cnt == MEM_LAT) begin
                  lat_cnt       = 0;
                  bus.mem_ack_i = 1'b1;
                  if (bus.mem_write_o) mem_lines[bus.mem_addr_o[11:5]] = bus.mem_data_o;
                  else bus.mem_data_i = mem_lines[bus.mem_addr_o[11:5]];
               end
            end else begin
               lat_cnt = 0;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int stalls, output logic [31:0] rdata);
      @(negedge clk);
      bus.p1_MemRead_i  = !wr;
      bus.p1_MemWrite_i = wr;
      bus.p1_addr_i     = addr;
      bus.p1_data_i     = wdata;
      stalls       = 0;
      wb_seen      = 0;
      rf_seen      = 0;
      rf_write_bad = 0;
      #1;
      while (bus.p1_stall_o === 1'b1 && stalls < 200) begin
         if (bus.mem_enable_o && bus.mem_write_o) begin
            wb_seen++;
            wb_addr = bus.mem_addr_o;
            wb_data = bus.mem_data_o;
         end
         if (bus.mem_enable_o && !bus.mem_write_o) begin
            rf_seen++;
            if (rf_seen == 1) rf_addr = bus.mem_addr_o;
            else if (bus.mem_addr_o !== rf_addr) rf_write_bad++;
         end
         stalls++;
         @(negedge clk);
         #1;
      end
      if (stalls >= 200) begin
         n_checks++;
         $display("FAIL access_timeout addr=%h stall still high after %0d cycles", addr, stalls);
      end
      rdata = bus.p1_data_o;
      @(posedge clk);
      #1;
      bus.p1_MemRead_i  = 1'b0;
      bus.p1_MemWrite_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.p1_MemRead_i  = 1'b0;
      bus.p1_MemWrite_i = 1'b0;
      bus.p1_addr_i     = 32'h0;
      bus.p1_data_i     = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.p1_stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.p1_stall_o);
      else n_pass++;
      n_checks++;
      if (bus.mem_enable_o !== 1'b0) $display("FAIL reset_mem_enable got=%b exp=0", bus.mem_enable_o);
      else n_pass++;
      n_checks++;
      if (bus.mem_write_o !== 1'b0) $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write_o);
      else n_pass++;
      n_checks++;
      if (bus.mem_addr_o !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr_o);
      else n_pass++;
      n_checks++;
      if (bus.mem_data_o !== 256'h0) $display("FAIL reset_mem_data got=%h exp=0", bus.mem_data_o);
      else n_pass++;
      n_checks++;
      if (bus.p1_data_o !== 32'h0) $display("FAIL reset_p1_data got=%h exp=0", bus.p1_data_o);
      else n_pass++;
   endtask

   task automatic test_clean_miss;
      int          st;
      logic [31:0] rd;
      access(1'b0, 32'h0000_0040, 32'h0, st, rd);
      n_checks++;
      if (st !== 12) $display("FAIL clean_miss_stalls got=%0d exp=12", st);
      else n_pass++;
      n_checks++;
      if (rf_addr !== 32'h40 || rf_seen == 0) $display("FAIL clean_miss_rf_addr got=%h exp=40", rf_addr);
      else n_pass++;
      n_checks++;
      if (wb_seen !== 0 || rf_write_bad !== 0)
         $display("FAIL clean_miss_no_write got=%0d/%0d exp=0/0", wb_seen, rf_write_bad);
      else n_pass++;
      n_checks++;
      if (rd !== 32'hAABB_CCDD) $display("FAIL clean_miss_data got=%h exp=aabbccdd", rd);
      else n_pass++;
   endtask

   task automatic test_write_hit;
      int          st;
      logic [31:0] rd;
      access(1'b1, 32'h0000_0044, 32'h1234_5678, st, rd);
      n_checks++;
      if (st !== 0 || rf_seen !== 0 || wb_seen !== 0)
         $display("FAIL write_hit_traffic got=%0d/%0d/%0d exp=0/0/0", st, rf_seen, wb_seen);
      else n_pass++;
      access(1'b0, 32'h0000_0044, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'h1234_5678)
         $display("FAIL write_hit_readback got=%0d,%h exp=0,12345678", st, rd);
      else n_pass++;
      access(1'b0, 32'h0000_0040, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'hAABB_CCDD)
         $display("FAIL write_hit_neighbour got=%0d,%h exp=0,aabbccdd", st, rd);
      else n_pass++;
   endtask

   task automatic test_dirty_evict;
      int          st;
      logic [31:0] rd;
      access(1'b0, 32'h0000_0440, 32'h0, st, rd);
      n_checks++;
      if (wb_seen == 0 || wb_addr !== 32'h40) $display("FAIL evict_wb_addr got=%h exp=40", wb_addr);
      else n_pass++;
      n_checks++;
      if (wb_data[63:0] !== 64'h1234_5678_AABB_CCDD)
         $display("FAIL evict_wb_data got=%h exp=12345678aabbccdd", wb_data[63:0]);
      else n_pass++;
      n_checks++;
      if (rf_addr !== 32'h440 || rf_write_bad !== 0) $display("FAIL evict_rf_addr got=%h exp=440", rf_addr);
      else n_pass++;
      n_checks++;
      if (st !== 21) $display("FAIL evict_stalls got=%0d exp=21", st);
      else n_pass++;
      n_checks++;
      if (rd !== 32'h5A22_0000) $display("FAIL evict_data got=%h exp=5a220000", rd);
      else n_pass++;
   endtask

   task automatic test_store_miss;
      int          st;
      logic [31:0] rd;
      access(1'b1, 32'h0000_0880, 32'hDEAD_BEEF, st, rd);
      n_checks++;
      if (st !== 12 || wb_seen !== 0 || rf_addr !== 32'h880)
         $display("FAIL store_miss got=%0d,%0d,%h exp=12,0,880", st, wb_seen, rf_addr);
      else n_pass++;
      access(1'b0, 32'h0000_0880, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'hDEAD_BEEF) $display("FAIL store_miss_merge got=%0d,%h exp=0,deadbeef", st, rd);
      else n_pass++;
      access(1'b0, 32'h0000_0884, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'h5A44_0001) $display("FAIL store_miss_word1 got=%0d,%h exp=0,5a440001", st, rd);
      else n_pass++;
      access(1'b0, 32'h0000_0C80, 32'h0, st, rd);
      n_checks++;
      if (wb_seen == 0 || wb_addr !== 32'h880 || wb_data[31:0] !== 32'hDEAD_BEEF)
         $display("FAIL store_miss_evict got=%h,%h exp=880,deadbeef", wb_addr, wb_data[31:0]);
      else n_pass++;
      n_checks++;
      if (st !== 21 || rd !== 32'h5A64_0000) $display("FAIL alias_load got=%0d,%h exp=21,5a640000", st, rd);
      else n_pass++;
   endtask

   task automatic test_spurious_ack;
      int          st;
      logic [31:0] rd;
      mem_auto = 1'b0;
      @(negedge clk);
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (bus.p1_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0)
            $display("FAIL idle_quiet cyc=%0d got=%b%b exp=00", k, bus.p1_stall_o, bus.mem_enable_o);
         else n_pass++;
      end
      mem_auto = 1'b1;
      access(1'b0, 32'h0000_0440, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'h5A22_0000) $display("FAIL idle_hit got=%0d,%h exp=0,5a220000", st, rd);
      else n_pass++;
   endtask

   task automatic test_boundary;
      int          st;
      logic [31:0] rd;
      access(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, st, rd);
      n_checks++;
      if (st !== 12 || rf_addr !== 32'hFFFF_FFE0)
         $display("FAIL top_addr_refill got=%0d,%h exp=12,ffffffe0", st, rf_addr);
      else n_pass++;
      access(1'b0, 32'hFFFF_FFFC, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'hCAFE_F00D) $display("FAIL top_addr_word7 got=%0d,%h exp=0,cafef00d", st, rd);
      else n_pass++;
      access(1'b0, 32'hFFFF_FFE0, 32'h0, st, rd);
      n_checks++;
      if (st !== 0 || rd !== 32'h5A7F_0000) $display("FAIL top_addr_word0 got=%0d,%h exp=0,5a7f0000", st, rd);
      else n_pass++;
   endtask

   task automatic test_reset_mid_refill;
      int          st;
      logic [31:0] rd;
      mem_auto = 1'b0;
      @(negedge clk);
      bus.p1_MemRead_i = 1'b1;
      bus.p1_addr_i    = 32'h0000_0100;
      repeat (4) @(negedge clk);
      #1;
      n_checks++;
      if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h100
          || bus.p1_stall_o !== 1'b1)
         $display("FAIL mid_refill_req got=%b%b,%h,%b exp=10,100,1", bus.mem_enable_o,
                  bus.mem_write_o, bus.mem_addr_o, bus.p1_stall_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      bus.p1_MemRead_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_enable_o !== 1'b0 || bus.p1_stall_o !== 1'b0)
         $display("FAIL mid_refill_abort got=%b%b exp=00", bus.mem_enable_o, bus.p1_stall_o);
      else n_pass++;
      @(negedge clk);
      bus.mem_ack_i = 1'b1;
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_enable_o !== 1'b0 || bus.p1_stall_o !== 1'b0)
         $display("FAIL late_ack got=%b%b exp=00", bus.mem_enable_o, bus.p1_stall_o);
      else n_pass++;
      mem_auto = 1'b1;
      access(1'b0, 32'h0000_0440, 32'h0, st, rd);
      n_checks++;
      if (st !== 12 || wb_seen !== 0 || rf_addr !== 32'h440 || rd !== 32'h5A22_0000)
         $display("FAIL post_reset_miss got=%0d,%0d,%h,%h exp=12,0,440,5a220000", st, wb_seen,
                  rf_addr, rd);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mem_auto = 1'b1;
      for (int i = 0; i < 128; i++) begin
         for (int w = 0; w < 8; w++) begin
            mem_lines[i][32*w +: 32] = 32'h5A00_0000 | (i << 16) | w;
         end
      end
      mem_lines[2][31:0] = 32'hAABB_CCDD;
      test_reset();
      test_clean_miss();
      test_write_hit();
      test_dirty_evict();
      test_store_miss();
      test_spurious_ack();
      test_boundary();
      test_reset_mid_refill();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
